// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1xN packet router.
package router_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StDrop  = 2'd2;
  localparam logic [1:0] StCheck = 2'd3;

  localparam int unsigned ErrParity = 0;
  localparam int unsigned ErrLength = 1;

  // Destination field width; at least one bit even for a single port.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_port_fifo.sv
// One output port of the router: FIFO with registered read data and a read-timeout flush.
module router_port_fifo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              do_wr, do_rd;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A read on the expiry cycle rescues the port, so flush never coincides with a read.
  assign flush_o = !empty_o && !rd_en_i && (tmo_q == TmoW'(TIMEOUT - 1));
  assign do_wr   = wr_en_i && !full_o && !flush_o;
  assign do_rd   = rd_en_i && !empty_o;
  assign data_o  = data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    if (flush_o) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      tmo_d    = '0;
      data_d   = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        data_d   = mem_q[rd_ptr_q];
      end
      count_d = count_q + CntW'(do_wr) - CntW'(do_rd);
      tmo_d   = (empty_o || rd_en_i) ? '0 : tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/router_1xn.sv
// 1xN byte-stream packet router: header-addressed steering into per-port FIFOs with
// parity/length checking, invalid-destination drop and timeout-flush recovery.
module router_1xn
  import router_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned N_PORTS = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pkt_valid,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      busy,
  input  logic [N_PORTS-1:0]        read_enb,
  output logic [N_PORTS-1:0]        valid_out,
  output logic [N_PORTS*DATA_W-1:0] data_out,
  output logic [1:0]                error,
  output logic [7:0]                drop_count
);

  localparam int unsigned ADDR_W = addr_w(N_PORTS);
  localparam int unsigned LenW   = DATA_W - ADDR_W;
  localparam int unsigned CntW   = LenW + 1;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [CntW-1:0]    paycnt_q, paycnt_d;
  logic [DATA_W-1:0]  parity_q, parity_d;
  logic [1:0]         error_q, error_d;
  logic [7:0]         drop_q, drop_d;

  logic [N_PORTS-1:0] full, empty, flush, wr_en;
  logic [ADDR_W-1:0]  hdr_dest;
  logic [LenW-1:0]    hdr_len;
  logic               hdr_ok, hdr_port_busy, dest_full, dest_flush;

  assign hdr_dest   = data_in[ADDR_W-1:0];
  assign hdr_len    = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok     = (32'(hdr_dest) < N_PORTS);
  assign valid_out  = ~empty;
  assign error      = error_q;
  assign drop_count = drop_q;

  always_comb begin
    hdr_port_busy = 1'b0;
    dest_full     = 1'b0;
    dest_flush    = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (hdr_dest == ADDR_W'(i)) hdr_port_busy = !empty[i];
      if (dest_q == ADDR_W'(i)) begin
        dest_full  = full[i];
        dest_flush = flush[i];
      end
    end
  end

  // One packet per FIFO: a header waits until its port has fully drained.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      StIdle:  busy = pkt_valid && hdr_ok && hdr_port_busy;
      StLoad:  busy = dest_full;
      StDrop:  busy = 1'b0;
      StCheck: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (state_q == StIdle && pkt_valid && !busy && hdr_dest == ADDR_W'(i)) wr_en[i] = 1'b1;
      if (state_q == StLoad && !busy && dest_q == ADDR_W'(i)) wr_en[i] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    paycnt_d = paycnt_q;
    parity_d = parity_q;
    error_d  = error_q;
    drop_d   = drop_q;
    case (state_q)
      StIdle: begin
        if (pkt_valid && !busy) begin
          if (!hdr_ok) begin
            state_d = StDrop;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            state_d  = StLoad;
            dest_d   = hdr_dest;
            len_d    = hdr_len;
            paycnt_d = '0;
            parity_d = data_in;
            error_d  = 2'b00;
          end
        end
      end
      StLoad: begin
        if (dest_flush) begin
          // The packet's FIFO was just emptied; discard whatever of it is still to come.
          error_d[ErrLength] = 1'b1;
          state_d = (!busy && !pkt_valid) ? StIdle : StDrop;
        end else if (!busy) begin
          // Folding the parity beat in leaves zero when it matches.
          parity_d = parity_q ^ data_in;
          if (pkt_valid) begin
            if (paycnt_q != '1) paycnt_d = paycnt_q + 1'b1;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StDrop: begin
        if (!pkt_valid) state_d = StIdle;
      end
      StCheck: begin
        error_d[ErrParity] = |parity_q;
        error_d[ErrLength] = (paycnt_q != {1'b0, len_q});
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      dest_q   <= '0;
      len_q    <= '0;
      paycnt_q <= '0;
      parity_q <= '0;
      error_q  <= 2'b00;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      paycnt_q <= paycnt_d;
      parity_q <= parity_d;
      error_q  <= error_d;
      drop_q   <= drop_d;
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    router_port_fifo #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clock_i   (clock),
      .reset_i   (reset),
      .wr_en_i   (wr_en[i]),
      .wr_data_i (data_in),
      .rd_en_i   (read_enb[i]),
      .full_o    (full[i]),
      .empty_o   (empty[i]),
      .flush_o   (flush[i]),
      .data_o    (data_out[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn: per-port expected-beat queues filled as beats are driven.
module tb_router_1xn;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned N_PORTS = 3;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 30;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      pkt_valid = 1'b0;
  logic [DATA_W-1:0]         data_in = '0;
  logic                      busy;
  logic [N_PORTS-1:0]        read_enb = '0;
  logic [N_PORTS-1:0]        valid_out;
  logic [N_PORTS*DATA_W-1:0] data_out;
  logic [1:0]                error;
  logic [7:0]                drop_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit tx_busy = 1'b0;
  logic [7:0] sb [N_PORTS][$];

  router_1xn #(
    .DATA_W  (DATA_W),
    .N_PORTS (N_PORTS),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .busy       (busy),
    .read_enb   (read_enb),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .error      (error),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1);
  end

  // Presents one beat and holds it until an edge consumes it (busy low).
  task automatic send_beat(input logic v, input logic [7:0] d);
    int waited;
    waited = 0;
    pkt_valid = v;
    data_in   = d;
    #1;
    while (busy) begin
      if (waited == 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got busy=1 for 200 cycles, expected beat %h accepted", d);
        break;
      end
      @(posedge clock); #1;
      waited++;
    end
    @(posedge clock); #1;
  endtask

  task automatic send_pkt(input int dest, input int len, input int npay, input logic [7:0] seed,
                          input bit corrupt, input bit store);
    logic [7:0] hdr, par, b;
    hdr = {len[5:0], dest[1:0]};
    par = hdr;
    if (store) sb[dest].push_back(hdr);
    send_beat(1'b1, hdr);
    for (int i = 0; i < npay; i++) begin
      b = 8'(seed * (i + 1));
      par ^= b;
      if (store) sb[dest].push_back(b);
      send_beat(1'b1, b);
    end
    b = corrupt ? 8'h00 : par;
    if (store) sb[dest].push_back(b);
    send_beat(1'b0, b);
    @(posedge clock); #1;
  endtask

  task automatic drain(input int p, input int max_cycles);
    logic was_valid;
    logic [7:0] exp;
    bit done;
    done = 1'b0;
    read_enb[p] = 1'b1;
    for (int c = 0; c < max_cycles && !done; c++) begin
      was_valid = valid_out[p];
      @(posedge clock); #1;
      if (was_valid) begin
        vectors++;
        if (sb[p].size() == 0) begin
          miscompares++;
          $display("FAIL drain%0d_extra: got %h, expected no beat", p, data_out[p*8 +: 8]);
        end else begin
          exp = sb[p].pop_front();
          if (data_out[p*8 +: 8] !== exp) begin
            miscompares++;
            $display("FAIL drain%0d_data: got %h, expected %h", p, data_out[p*8 +: 8], exp);
          end
        end
      end
      if (!tx_busy && sb[p].size() == 0 && !valid_out[p]) done = 1'b1;
    end
    read_enb[p] = 1'b0;
    vectors++;
    if (sb[p].size() != 0) begin
      miscompares++;
      $display("FAIL drain%0d_left: got %0d beats unread, expected 0", p, sb[p].size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (valid_out !== 3'b000) begin
      miscompares++; $display("FAIL reset_valid: got %b, expected 000", valid_out);
    end
    vectors++;
    if (data_out !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h, expected 0", data_out);
    end
    vectors++;
    if ({busy, error, drop_count} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_status: got busy=%b err=%b drop=%0d, expected 0", busy, error, drop_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_route_read;
    logic [7:0] exp;
    send_pkt(1, 3, 3, 8'h11, 1'b0, 1'b1);
    vectors++;
    if (error !== 2'b00) begin
      miscompares++; $display("FAIL route_error: got %b, expected 00", error);
    end
    vectors++;
    if (valid_out !== 3'b010) begin
      miscompares++; $display("FAIL route_valid: got %b, expected 010", valid_out);
    end
    read_enb[1] = 1'b1;
    #1;
    vectors++;
    if (data_out[15:8] !== 8'h00) begin
      miscompares++; $display("FAIL route_latency: got %h before edge, expected 00", data_out[15:8]);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      exp = sb[1].pop_front();
      vectors++;
      if (data_out[15:8] !== exp) begin
        miscompares++; $display("FAIL route_read%0d: got %h, expected %h", i, data_out[15:8], exp);
      end
    end
    read_enb[1] = 1'b0;
    vectors++;
    if (valid_out !== 3'b000) begin
      miscompares++; $display("FAIL route_empty: got %b, expected 000", valid_out);
    end
  endtask

  task automatic test_parity_length;
    logic [7:0] par;
    send_pkt(1, 3, 3, 8'h11, 1'b1, 1'b1);
    vectors++;
    if (error !== 2'b01) begin
      miscompares++; $display("FAIL parity_error: got %b, expected 01", error);
    end
    drain(1, 40);
    vectors++;
    if (error !== 2'b01) begin
      miscompares++; $display("FAIL parity_hold: got %b, expected 01", error);
    end
    // Header dest2 len2, followed by three payloads.
    par = 8'h0A;
    sb[2].push_back(8'h0A);
    send_beat(1'b1, 8'h0A);
    vectors++;
    if (error !== 2'b00) begin
      miscompares++; $display("FAIL error_clear: got %b, expected 00", error);
    end
    for (int i = 1; i <= 3; i++) begin
      par ^= 8'(i);
      sb[2].push_back(8'(i));
      send_beat(1'b1, 8'(i));
    end
    sb[2].push_back(par);
    send_beat(1'b0, par);
    @(posedge clock); #1;
    vectors++;
    if (error !== 2'b10) begin
      miscompares++; $display("FAIL length_error: got %b, expected 10", error);
    end
    drain(2, 40);
  endtask

  task automatic test_backpressure;
    logic [7:0] hdr, par, exp;
    hdr = {6'd20, 2'd2};
    par = hdr;
    sb[2].push_back(hdr);
    send_beat(1'b1, hdr);
    for (int i = 0; i < 15; i++) begin
      par ^= 8'(8'h40 + i);
      sb[2].push_back(8'(8'h40 + i));
      send_beat(1'b1, 8'(8'h40 + i));
    end
    pkt_valid = 1'b1;
    data_in   = 8'h4F;
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL bp_full_busy: got %b, expected 1", busy);
    end
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({busy, valid_out[2]} !== 2'b11) begin
      miscompares++; $display("FAIL bp_stall: got busy=%b valid=%b, expected 1 1", busy, valid_out[2]);
    end
    read_enb[2] = 1'b1;
    @(posedge clock); #1;
    read_enb[2] = 1'b0;
    exp = sb[2].pop_front();
    vectors++;
    if (data_out[23:16] !== exp) begin
      miscompares++; $display("FAIL bp_read: got %h, expected %h", data_out[23:16], exp);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_release: got %b, expected 0", busy);
    end
    par ^= 8'h4F;
    sb[2].push_back(8'h4F);
    @(posedge clock); #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL bp_one_more: got %b, expected 1", busy);
    end
    tx_busy = 1'b1;
    fork
      begin
        for (int i = 16; i < 20; i++) begin
          par ^= 8'(8'h40 + i);
          sb[2].push_back(8'(8'h40 + i));
          send_beat(1'b1, 8'(8'h40 + i));
        end
        sb[2].push_back(par);
        send_beat(1'b0, par);
        tx_busy = 1'b0;
      end
      begin
        drain(2, 200);
      end
    join
    vectors++;
    if (error !== 2'b00) begin
      miscompares++; $display("FAIL bp_error: got %b, expected 00", error);
    end
  endtask

  task automatic test_invalid_dest;
    send_pkt(3, 1, 1, 8'h55, 1'b0, 1'b0);
    vectors++;
    if (drop_count !== 8'd1) begin
      miscompares++; $display("FAIL drop_count: got %0d, expected 1", drop_count);
    end
    vectors++;
    if ({valid_out, error} !== 5'b00000) begin
      miscompares++; $display("FAIL drop_quiet: got valid=%b err=%b, expected 000 00", valid_out, error);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] exp;
    int t0, delta;
    bit fell;
    send_pkt(0, 1, 1, 8'hA5, 1'b0, 1'b1);
    read_enb[0] = 1'b1;
    @(posedge clock); #1;
    read_enb[0] = 1'b0;
    t0 = cyc;
    exp = sb[0].pop_front();
    vectors++;
    if (data_out[7:0] !== exp) begin
      miscompares++; $display("FAIL tmo_read: got %h, expected %h", data_out[7:0], exp);
    end
    fell = 1'b0;
    for (int c = 0; c < 100 && !fell; c++) begin
      @(posedge clock); #1;
      if (!valid_out[0]) fell = 1'b1;
    end
    delta = fell ? cyc - t0 : -1;
    vectors++;
    if (delta != TIMEOUT) begin
      miscompares++; $display("FAIL tmo_cycles: got %0d, expected %0d", delta, TIMEOUT);
    end
    vectors++;
    if ({data_out[7:0], error} !== 10'd0) begin
      miscompares++; $display("FAIL tmo_clear: got data=%h err=%b, expected 00 00", data_out[7:0], error);
    end
    sb[0].delete();
  endtask

  task automatic test_timeout_mid_load;
    send_pkt(0, 40, 40, 8'h03, 1'b0, 1'b0);
    vectors++;
    if (error !== 2'b10) begin
      miscompares++; $display("FAIL midload_error: got %b, expected 10", error);
    end
    vectors++;
    if (valid_out !== 3'b000) begin
      miscompares++; $display("FAIL midload_valid: got %b, expected 000", valid_out);
    end
    vectors++;
    if (drop_count !== 8'd1) begin
      miscompares++; $display("FAIL midload_drops: got %0d, expected 1", drop_count);
    end
  endtask

  task automatic test_drop_saturate;
    for (int i = 0; i < 254; i++) begin
      send_beat(1'b1, 8'h03);
      send_beat(1'b0, 8'h03);
    end
    vectors++;
    if (drop_count !== 8'd255) begin
      miscompares++; $display("FAIL drop_255: got %0d, expected 255", drop_count);
    end
    send_beat(1'b1, 8'h03);
    send_beat(1'b0, 8'h03);
    vectors++;
    if (drop_count !== 8'd255) begin
      miscompares++; $display("FAIL drop_saturate: got %0d, expected 255", drop_count);
    end
  endtask

  task automatic test_reset_mid_load;
    send_beat(1'b1, 8'h15);
    read_enb[1] = 1'b1;
    send_beat(1'b1, 8'h61);
    read_enb[1] = 1'b0;
    vectors++;
    if (data_out[15:8] !== 8'h15) begin
      miscompares++; $display("FAIL rst_pre_read: got %h, expected 15", data_out[15:8]);
    end
    send_beat(1'b1, 8'h62);
    reset = 1'b1;
    pkt_valid = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if ({valid_out, data_out} !== '0) begin
      miscompares++; $display("FAIL rst_mid_ports: got valid=%b data=%h, expected 0", valid_out, data_out);
    end
    vectors++;
    if ({busy, error, drop_count} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_mid_status: got busy=%b err=%b drop=%0d, expected 0", busy, error, drop_count);
    end
    reset = 1'b0;
    sb[1].delete();
    send_pkt(1, 2, 2, 8'h30, 1'b0, 1'b1);
    vectors++;
    if ({valid_out, error} !== 5'b01000) begin
      miscompares++; $display("FAIL rst_after: got valid=%b err=%b, expected 010 00", valid_out, error);
    end
    drain(1, 40);
  endtask

  initial begin
    test_reset();
    test_route_read();
    test_parity_length();
    test_backpressure();
    test_invalid_dest();
    test_timeout();
    test_timeout_mid_load();
    test_drop_saturate();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
